// File: rtl/rmw_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a read-first RAM doing read-modify-write.
// Two-stage pipeline (S1 read issue, S2 merge/write/respond) with a write bypass for back-to-back hits.
module rmw_mem_arbiter #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_din,
    input  logic [DATA_W-1:0] a_wen,
    output logic              a_gnt,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_din,
    input  logic [DATA_W-1:0] b_wen,
    output logic              b_gnt,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy
);

    logic              last_b_q;  // 1: B won the most recent transfer
    logic              a_xfer, b_xfer;

    logic              s1_valid_q, s1_valid_d;
    logic              s1_id_q, s1_id_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
    logic [DATA_W-1:0] s1_din_q, s1_din_d;
    logic [DATA_W-1:0] s1_wen_q, s1_wen_d;

    logic              s2_valid_q;
    logic              s2_id_q;
    logic [ADDR_W-1:0] s2_addr_q;
    logic [DATA_W-1:0] s2_din_q;
    logic [DATA_W-1:0] s2_wen_q;

    logic              byp_hit_q, byp_hit_d;
    logic [DATA_W-1:0] byp_data_q;
    logic [DATA_W-1:0] old_word, merged;

    always_comb begin
        a_gnt = ~reset & a_req & (~b_req | last_b_q);
        b_gnt = ~reset & b_req & (~a_req | ~last_b_q);
    end

    assign a_xfer = a_req & a_gnt;
    assign b_xfer = b_req & b_gnt;

    always_comb begin
        s1_valid_d = a_xfer | b_xfer;
        s1_id_d    = b_xfer;
        s1_addr_d  = b_xfer ? b_addr : a_addr;
        s1_din_d   = b_xfer ? b_din : a_din;
        s1_wen_d   = b_xfer ? b_wen : a_wen;
    end

    // The RAM read issued from S1 misses a write committed on that same edge by S2.
    always_comb begin
        byp_hit_d = s1_valid_q & s2_valid_q & (|s2_wen_q) & (s1_addr_q == s2_addr_q);
    end

    always_comb begin
        old_word = reset ? '0 : (byp_hit_q ? byp_data_q : ram_rd_data);
        merged   = (s2_din_q & s2_wen_q) | (old_word & ~s2_wen_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_b_q   <= 1'b1;
            s1_valid_q <= 1'b0;
            s1_id_q    <= 1'b0;
            s1_addr_q  <= '0;
            s1_din_q   <= '0;
            s1_wen_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_id_q    <= 1'b0;
            s2_addr_q  <= '0;
            s2_din_q   <= '0;
            s2_wen_q   <= '0;
            byp_hit_q  <= 1'b0;
            byp_data_q <= '0;
        end else begin
            if (a_xfer || b_xfer) begin
                last_b_q <= b_xfer;
            end
            s1_valid_q <= s1_valid_d;
            s1_id_q    <= s1_id_d;
            s1_addr_q  <= s1_addr_d;
            s1_din_q   <= s1_din_d;
            s1_wen_q   <= s1_wen_d;
            s2_valid_q <= s1_valid_q;
            s2_id_q    <= s1_id_q;
            s2_addr_q  <= s1_addr_q;
            s2_din_q   <= s1_din_q;
            s2_wen_q   <= s1_wen_q;
            byp_hit_q  <= byp_hit_d;
            byp_data_q <= merged;
        end
    end

    always_comb begin
        ram_rd_en   = s1_valid_q;
        ram_rd_addr = s1_addr_q;
        ram_wr_en   = s2_valid_q & (|s2_wen_q);
        ram_wr_addr = s2_addr_q;
        ram_wr_data = merged;
        rsp_valid   = s2_valid_q;
        rsp_id      = s2_id_q;
        rsp_rdata   = old_word;
        busy        = s1_valid_q | s2_valid_q;
    end

endmodule

// File: tb/tb_rmw_mem_arbiter.sv
// Directed bench for rmw_mem_arbiter with a behavioural read-first RAM.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_rmw_mem_arbiter;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_req, b_req, a_gnt, b_gnt;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_din, b_din, a_wen, b_wen;
    logic          ram_rd_en, ram_wr_en;
    logic [AW-1:0] ram_rd_addr, ram_wr_addr;
    logic [DW-1:0] ram_rd_data, ram_wr_data;
    logic          rsp_valid, rsp_id, busy;
    logic [DW-1:0] rsp_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rmw_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .a_req      (a_req),
        .a_addr     (a_addr),
        .a_din      (a_din),
        .a_wen      (a_wen),
        .a_gnt      (a_gnt),
        .b_req      (b_req),
        .b_addr     (b_addr),
        .b_din      (b_din),
        .b_wen      (b_wen),
        .b_gnt      (b_gnt),
        .ram_rd_en  (ram_rd_en),
        .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data),
        .ram_wr_en  (ram_wr_en),
        .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_rdata  (rsp_rdata),
        .busy       (busy)
    );

    // Read-first RAM with a preload port used only while the DUT is in reset
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = addr;
        pl_data = data;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        a_req  = 1'b0;
        b_req  = 1'b0;
        a_addr = '0;
        b_addr = '0;
        a_din  = '0;
        b_din  = '0;
        a_wen  = '0;
        b_wen  = '0;
        pl_en  = 1'b0;
        pl_addr = '0;
        pl_data = '0;

        preload(10'd5, 16'h00FF);
        preload(10'd3, 16'h0000);
        preload(10'd7, 16'h1234);

        // Outputs held low in reset even with requests present
        @(negedge clk);
        a_req = 1'b1;
        b_req = 1'b1;
        #1;
        check("rst_a_gnt", 32'(a_gnt), 32'h0);
        check("rst_b_gnt", 32'(b_gnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_rd_en", 32'(ram_rd_en), 32'h0);
        check("rst_wr_en", 32'(ram_wr_en), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rd_addr", 32'(ram_rd_addr), 32'h0);
        check("rst_wr_data", 32'(ram_wr_data), 32'h0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
        a_req = 1'b0;
        b_req = 1'b0;
        reset = 1'b0;

        // Single masked write: (AAAA&F0F0)|(00FF&0F0F) = A0AF
        @(negedge clk);
        a_req = 1'b1; a_addr = 10'd5; a_din = 16'hAAAA; a_wen = 16'hF0F0;
        #1;
        check("w5_a_gnt", 32'(a_gnt), 32'h1);
        check("w5_b_gnt", 32'(b_gnt), 32'h0);
        @(negedge clk);
        a_req = 1'b0;
        #1;
        check("w5_rd_en", 32'(ram_rd_en), 32'h1);
        check("w5_rd_addr", 32'(ram_rd_addr), 32'd5);
        check("w5_busy", 32'(busy), 32'h1);
        check("w5_rsp_early", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        #1;
        check("w5_rsp_valid", 32'(rsp_valid), 32'h1);
        check("w5_rsp_id", 32'(rsp_id), 32'h0);
        check("w5_rsp_rdata", 32'(rsp_rdata), 32'h00FF);
        check("w5_wr_en", 32'(ram_wr_en), 32'h1);
        check("w5_wr_addr", 32'(ram_wr_addr), 32'd5);
        check("w5_wr_data", 32'(ram_wr_data), 32'hA0AF);
        @(negedge clk);
        #1;
        check("w5_rsp_done", 32'(rsp_valid), 32'h0);
        check("w5_idle", 32'(busy), 32'h0);

        // Fresh reset, then both requesting for 4 cycles: A,B,A,B
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        a_addr = 10'd10; b_addr = 10'd11; a_wen = '0; b_wen = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a_req = (i < 4);
            b_req = (i < 4);
            #1;
            if (i < 4) begin
                check($sformatf("rr_a_gnt%0d", i), 32'(a_gnt), 32'((i % 2) == 0));
                check($sformatf("rr_b_gnt%0d", i), 32'(b_gnt), 32'((i % 2) == 1));
            end
            if (i >= 2) begin
                check($sformatf("rr_rsp_valid%0d", i), 32'(rsp_valid), 32'h1);
                check($sformatf("rr_rsp_id%0d", i), 32'(rsp_id), 32'((i - 2) % 2));
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (2) @(negedge clk);

        // Back-to-back writes to addr 3: second must see the first via bypass
        @(negedge clk);
        a_req = 1'b1; a_addr = 10'd3; a_din = 16'hFFFF; a_wen = 16'h000F;
        #1;
        check("raw_a_gnt", 32'(a_gnt), 32'h1);
        @(negedge clk);
        a_req = 1'b0;
        b_req = 1'b1; b_addr = 10'd3; b_din = 16'hFFFF; b_wen = 16'h00F0;
        #1;
        check("raw_b_gnt", 32'(b_gnt), 32'h1);
        @(negedge clk);
        b_req = 1'b0;
        #1;
        check("raw_a_id", 32'(rsp_id), 32'h0);
        check("raw_a_rdata", 32'(rsp_rdata), 32'h0000);
        check("raw_a_wr_data", 32'(ram_wr_data), 32'h000F);
        @(negedge clk);
        #1;
        check("raw_b_valid", 32'(rsp_valid), 32'h1);
        check("raw_b_id", 32'(rsp_id), 32'h1);
        check("raw_b_rdata", 32'(rsp_rdata), 32'h000F);
        check("raw_b_wr_en", 32'(ram_wr_en), 32'h1);
        check("raw_b_wr_data", 32'(ram_wr_data), 32'h00FF);

        // Pure read by B
        @(negedge clk);
        b_req = 1'b1; b_addr = 10'd7; b_din = 16'hFFFF; b_wen = 16'h0000;
        #1;
        check("rd7_b_gnt", 32'(b_gnt), 32'h1);
        @(negedge clk);
        b_req = 1'b0;
        #1;
        check("rd7_wr_en_s1", 32'(ram_wr_en), 32'h0);
        @(negedge clk);
        #1;
        check("rd7_rsp_valid", 32'(rsp_valid), 32'h1);
        check("rd7_rsp_id", 32'(rsp_id), 32'h1);
        check("rd7_rsp_rdata", 32'(rsp_rdata), 32'h1234);
        check("rd7_wr_en", 32'(ram_wr_en), 32'h0);

        // Reset one cycle after accepting a write discards it
        @(negedge clk);
        a_req = 1'b1; a_addr = 10'd20; a_din = 16'hFFFF; a_wen = 16'hFFFF;
        #1;
        check("abort_a_gnt", 32'(a_gnt), 32'h1);
        @(negedge clk);
        a_req = 1'b0;
        reset = 1'b1;
        #1;
        check("abort_busy_now", 32'(busy), 32'h0);
        check("abort_rd_en_now", 32'(ram_rd_en), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("abort_wr_en%0d", i), 32'(ram_wr_en), 32'h0);
            check($sformatf("abort_rsp%0d", i), 32'(rsp_valid), 32'h0);
            check($sformatf("abort_busy%0d", i), 32'(busy), 32'h0);
        end

        // Tie after reset goes to A
        a_req = 1'b1;
        b_req = 1'b1;
        #1;
        check("tie_a_gnt", 32'(a_gnt), 32'h1);
        check("tie_b_gnt", 32'(b_gnt), 32'h0);
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
